// File: rtl/sram_arbiter_pkg.sv
// Shared encodings and width defaults for the SRAM arbiter and SRAM controller.
package sram_arbiter_pkg;

    localparam int SRAM_ADDR_W = 20;
    localparam int SRAM_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ACK   = 2'd3
    } arb_state_e;

    localparam logic OWNER_RD = 1'b0;
    localparam logic OWNER_WR = 1'b1;

endpackage

// File: rtl/sram_arb_prio.sv
// Read-priority grant decision with a streak counter that bounds write starvation.
module sram_arb_prio
    import sram_arbiter_pkg::*;
#(
    parameter int MAX_RD_STREAK = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic rd_req,
    input  logic wr_req,
    input  logic grant,
    output logic gnt_owner
);

    localparam logic [3:0] STREAK_MAX = 4'(MAX_RD_STREAK);

    logic [3:0] rd_streak_q;
    logic [3:0] rd_streak_d;
    logic       gnt_wr;

    assign gnt_wr    = wr_req && (!rd_req || (rd_streak_q == STREAK_MAX));
    assign gnt_owner = gnt_wr ? OWNER_WR : OWNER_RD;

    always_comb begin
        rd_streak_d = rd_streak_q;
        if (grant) begin
            if (gnt_wr) begin
                rd_streak_d = 4'd0;
            end else if (wr_req) begin
                // a pending write is being passed over: count it
                if (rd_streak_q != STREAK_MAX) begin
                    rd_streak_d = rd_streak_q + 4'd1;
                end
            end else begin
                rd_streak_d = 4'd0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_streak_q <= 4'd0;
        end else begin
            rd_streak_q <= rd_streak_d;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Two-port SRAM command arbiter: display reads vs camera writes, one command in flight.
// Optional WAIT watchdog with sticky err: define SRAM_TIMEOUT_EN.
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int ADDR_W        = SRAM_ADDR_W,
    parameter int DATA_W        = SRAM_DATA_W,
    parameter int MAX_RD_STREAK = 4,
    parameter int TIMEOUT       = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ack,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_done,
    output logic              busy,
    output logic              owner,
    output logic              err
);

    arb_state_e        state_q, state_d;
    logic              owner_q, owner_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic              rd_ack_q, rd_ack_d;
    logic              wr_ack_q, wr_ack_d;
    logic              grant;
    logic              gnt_owner;

`ifdef SRAM_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
    logic [7:0] tmo_cnt_q, tmo_cnt_d;
    logic       err_q, err_d;
`endif

    // a stale completion from the previous command blocks the next grant
    assign grant = (state_q == ST_IDLE) && !mem_done && (rd_req || wr_req);

    sram_arb_prio #(
        .MAX_RD_STREAK(MAX_RD_STREAK)
    ) u_prio (
        .clk      (clk),
        .rst      (rst),
        .rd_req   (rd_req),
        .wr_req   (wr_req),
        .grant    (grant),
        .gnt_owner(gnt_owner)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rd_data_d   = rd_data_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        rd_ack_d    = 1'b0;
        wr_ack_d    = 1'b0;
`ifdef SRAM_TIMEOUT_EN
        tmo_cnt_d   = tmo_cnt_q;
        err_d       = err_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (grant) begin
                    owner_d = gnt_owner;
                    state_d = ST_ISSUE;
                    if (gnt_owner == OWNER_WR) begin
                        addr_d      = wr_addr;
                        wdata_d     = wr_data;
                        mem_write_d = 1'b1;
                    end else begin
                        addr_d     = rd_addr;
                        mem_read_d = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
`ifdef SRAM_TIMEOUT_EN
                tmo_cnt_d = 8'd0;
`endif
            end
            ST_WAIT: begin
                if (mem_done) begin
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    rd_ack_d    = (owner_q == OWNER_RD);
                    wr_ack_d    = (owner_q == OWNER_WR);
                    state_d     = ST_ACK;
                    if (owner_q == OWNER_RD) begin
                        rd_data_d = mem_rdata;
                    end
                end
`ifdef SRAM_TIMEOUT_EN
                else if (tmo_cnt_q == TMO_LAST) begin
                    // abort but still ack so the requester never hangs
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    rd_ack_d    = (owner_q == OWNER_RD);
                    wr_ack_d    = (owner_q == OWNER_WR);
                    err_d       = 1'b1;
                    state_d     = ST_ACK;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 8'd1;
                end
`endif
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWNER_RD;
            addr_q      <= '0;
            wdata_q     <= '0;
            rd_data_q   <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            rd_ack_q    <= 1'b0;
            wr_ack_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rd_data_q   <= rd_data_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            rd_ack_q    <= rd_ack_d;
            wr_ack_q    <= wr_ack_d;
        end
    end

`ifdef SRAM_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_cnt_q <= 8'd0;
            err_q     <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            err_q     <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0 && (TIMEOUT != 0);
`endif

    assign busy      = (state_q != ST_IDLE);
    assign owner     = owner_q;
    assign rd_ack    = rd_ack_q;
    assign wr_ack    = wr_ack_q;
    assign rd_data   = rd_data_q;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed self-checking bench for sram_arbiter
// with a small SRAM controller model.
module tb_sram_arbiter;

  localparam int AW = 20;
  localparam int DW = 32;

  logic          clk;
  logic          rst;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rd_ack;
  logic [DW-1:0] rd_data;
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_ack;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_done;
  logic          busy;
  logic          owner;
  logic          err;

  int errors = 0;
  int checks = 0;

  int            lat = 2;
  bit            stuck = 0;
  bit            hang = 0;
  int            ccnt = 0;
  logic [DW-1:0] rdata_val = '0;

  logic          grants[$];
  logic          busy_prev = 0;
  bit            overlap = 0;
  int            rd_ack_cnt = 0;
  int            wr_ack_cnt = 0;

  sram_arbiter #(
    .ADDR_W       (AW),
    .DATA_W       (DW),
    .MAX_RD_STREAK(4),
    .TIMEOUT      (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rd_req   (rd_req),
    .rd_addr  (rd_addr),
    .rd_ack   (rd_ack),
    .rd_data  (rd_data),
    .wr_req   (wr_req),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_ack   (wr_ack),
    .mem_read (mem_read),
    .mem_write(mem_write),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_done (mem_done),
    .busy     (busy),
    .owner    (owner),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      ccnt     = 0;
      mem_done = 1'b0;
    end else if (mem_read || mem_write) begin
      ccnt = ccnt + 1;
      if (!hang && ccnt > lat) begin
        mem_done  = 1'b1;
        mem_rdata = rdata_val;
      end
    end else begin
      ccnt = 0;
      if (!stuck) mem_done = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (busy && !busy_prev) grants.push_back(owner);
    busy_prev = busy;
    if (mem_read && mem_write) overlap = 1;
    if (rd_ack) rd_ack_cnt++;
    if (wr_ack) wr_ack_cnt++;
  end

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({rd_ack, wr_ack, mem_read, mem_write,
         busy, owner, err} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 0000000",
               {rd_ack, wr_ack, mem_read, mem_write,
                busy, owner, err});
    end
    checks++;
    if (mem_addr !== '0 || mem_wdata !== '0 ||
        rd_data !== '0) begin
      errors++;
      $display("FAIL reset_data: addr=%h wdata=%h rdata=%h",
               mem_addr, mem_wdata, rd_data);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b expected 0", busy);
    end
  endtask

  task automatic test_single_read();
    int wr0;
    wr0       = wr_ack_cnt;
    lat       = 2;
    rdata_val = 32'hDEADBEEF;
    rd_addr   = 20'h00123;
    rd_req    = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      checks++;
      if (mem_read !== 1'b1 || rd_ack !== 1'b0) begin
        errors++;
        $display("FAIL rd_cmd_c%0d: mem_read=%b rd_ack=%b",
                 c, mem_read, rd_ack);
      end
    end
    checks++;
    if (mem_addr !== 20'h00123 || owner !== 1'b0 ||
        mem_write !== 1'b0) begin
      errors++;
      $display("FAIL rd_addr: addr=%h owner=%b wr=%b",
               mem_addr, owner, mem_write);
    end
    @(negedge clk);
    checks++;
    if (rd_ack !== 1'b1 || mem_read !== 1'b0) begin
      errors++;
      $display("FAIL rd_ack_c4: rd_ack=%b mem_read=%b",
               rd_ack, mem_read);
    end
    checks++;
    if (rd_data !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL rd_data: got %h expected deadbeef",
               rd_data);
    end
    rd_req = 1'b0;
    @(negedge clk);
    checks++;
    if (rd_ack !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rd_after: rd_ack=%b busy=%b",
               rd_ack, busy);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (wr_ack_cnt != wr0) begin
      errors++;
      $display("FAIL rd_no_wrack: pulses=%0d expected 0",
               wr_ack_cnt - wr0);
    end
  endtask

  task automatic test_single_write();
    int wr0;
    bit acked;
    bit saw_rd;
    bit cmd_ok;
    wr0     = wr_ack_cnt;
    acked   = 0;
    saw_rd  = 0;
    cmd_ok  = 0;
    lat     = 1;
    wr_addr = 20'h0FFFF;
    wr_data = 32'h01020304;
    wr_req  = 1'b1;
    for (int i = 0; i < 20 && !acked; i++) begin
      @(negedge clk);
      if (mem_read) saw_rd = 1;
      if (mem_write && mem_addr == 20'h0FFFF &&
          mem_wdata == 32'h01020304 && owner == 1'b1)
        cmd_ok = 1;
      if (wr_ack) begin
        acked  = 1;
        wr_req = 1'b0;
      end
    end
    checks++;
    if (!acked) begin
      errors++;
      $display("FAIL wr_ack_seen: got 0 expected 1");
    end
    checks++;
    if (!cmd_ok) begin
      errors++;
      $display("FAIL wr_cmd: addr/data/owner mismatch");
    end
    checks++;
    if (saw_rd) begin
      errors++;
      $display("FAIL wr_no_read: mem_read=1 expected 0");
    end
    repeat (3) @(negedge clk);
    checks++;
    if (wr_ack_cnt - wr0 != 1) begin
      errors++;
      $display("FAIL wr_one_pulse: pulses=%0d expected 1",
               wr_ack_cnt - wr0);
    end
    checks++;
    if (rd_data !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL wr_rd_data_kept: got %h", rd_data);
    end
  endtask

  task automatic test_streak();
    int         nrd;
    logic [5:0] exp;
    exp = 6'b010000;
    nrd = 0;
    lat = 0;
    grants.delete();
    rd_addr = 20'h00100;
    wr_addr = 20'h00200;
    wr_data = 32'h0000CAFE;
    rd_req  = 1'b1;
    wr_req  = 1'b1;
    for (int i = 0; i < 200 && nrd < 5; i++) begin
      @(negedge clk);
      if (wr_ack) wr_req = 1'b0;
      if (rd_ack) begin
        nrd++;
        if (nrd == 5) rd_req = 1'b0;
      end
    end
    checks++;
    if (nrd != 5) begin
      errors++;
      $display("FAIL streak_done: reads=%0d expected 5", nrd);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (grants.size() != 6) begin
      errors++;
      $display("FAIL streak_count: grants=%0d expected 6",
               grants.size());
    end
    for (int i = 0; i < 6 && i < grants.size(); i++) begin
      checks++;
      if (grants[i] !== exp[i]) begin
        errors++;
        $display("FAIL streak_g%0d: owner=%b expected %b",
                 i, grants[i], exp[i]);
      end
    end
  endtask

  task automatic test_simultaneous();
    bit rd_done;
    bit wr_done;
    rd_done = 0;
    wr_done = 0;
    lat     = 1;
    grants.delete();
    rd_addr = 20'h00AAA;
    wr_addr = 20'h00BBB;
    rd_req  = 1'b1;
    wr_req  = 1'b1;
    for (int i = 0; i < 60 && !(rd_done && wr_done); i++) begin
      @(negedge clk);
      if (rd_ack) begin rd_req = 1'b0; rd_done = 1; end
      if (wr_ack) begin wr_req = 1'b0; wr_done = 1; end
    end
    repeat (2) @(negedge clk);
    checks++;
    if (!(rd_done && wr_done)) begin
      errors++;
      $display("FAIL simul_done: rd=%b wr=%b expected 1 1",
               rd_done, wr_done);
    end
    checks++;
    if (grants.size() != 2 || grants[0] !== 1'b0 ||
        grants[1] !== 1'b1) begin
      errors++;
      $display("FAIL simul_order: n=%0d expected R then W",
               grants.size());
    end
    checks++;
    if (overlap) begin
      errors++;
      $display("FAIL no_overlap: mem_read&&mem_write seen");
    end
  endtask

  task automatic test_done_stuck();
    bit acked;
    bit moved;
    bit issued;
    acked     = 0;
    moved     = 0;
    issued    = 0;
    lat       = 1;
    stuck     = 1;
    rdata_val = 32'hA5A50055;
    rd_addr   = 20'h00055;
    rd_req    = 1'b1;
    for (int i = 0; i < 20 && !acked; i++) begin
      @(negedge clk);
      if (rd_ack) acked = 1;
    end
    rd_addr   = 20'h00066;
    rdata_val = 32'hA5A50066;
    checks++;
    if (!acked) begin
      errors++;
      $display("FAIL stuck_first_ack: got 0 expected 1");
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (busy) moved = 1;
    end
    checks++;
    if (moved || mem_done !== 1'b1) begin
      errors++;
      $display("FAIL stuck_hold: busy seen=%b done=%b",
               moved, mem_done);
    end
    stuck = 0;
    for (int i = 0; i < 3 && !issued; i++) begin
      @(negedge clk);
      if (mem_read) issued = 1;
    end
    checks++;
    if (!issued || mem_addr !== 20'h00066) begin
      errors++;
      $display("FAIL stuck_release: issued=%b addr=%h",
               issued, mem_addr);
    end
    acked = 0;
    for (int i = 0; i < 20 && !acked; i++) begin
      @(negedge clk);
      if (rd_ack) begin acked = 1; rd_req = 1'b0; end
    end
    checks++;
    if (!acked || rd_data !== 32'hA5A50066) begin
      errors++;
      $display("FAIL stuck_second: ack=%b data=%h",
               acked, rd_data);
    end
    repeat (2) @(negedge clk);
  endtask

`ifdef SRAM_TIMEOUT_EN
  task automatic test_timeout();
    bit early;
    bit cmd_drop;
    early    = 0;
    cmd_drop = 0;
    hang     = 1;
    rd_addr  = 20'h00088;
    rd_req   = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (rd_ack) early = 1;
      if (!mem_read) cmd_drop = 1;
    end
    checks++;
    if (early || cmd_drop || err !== 1'b0) begin
      errors++;
      $display("FAIL tmo_wait: early=%b drop=%b err=%b",
               early, cmd_drop, err);
    end
    @(negedge clk);
    checks++;
    if (rd_ack !== 1'b1 || err !== 1'b1 ||
        mem_read !== 1'b0) begin
      errors++;
      $display("FAIL tmo_ack: ack=%b err=%b rd=%b",
               rd_ack, err, mem_read);
    end
    checks++;
    if (rd_data !== 32'hA5A50066) begin
      errors++;
      $display("FAIL tmo_data: got %h expected a5a50066",
               rd_data);
    end
    rd_req = 1'b0;
    hang   = 0;
    repeat (2) @(negedge clk);
    checks++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL tmo_sticky: err=%b busy=%b", err, busy);
    end
  endtask
`else
  task automatic test_timeout();
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_tied: err=%b expected 0", err);
    end
  endtask
`endif

  task automatic test_reset_mid();
    int ack0;
    hang    = 1;
    rd_addr = 20'h00077;
    rd_req  = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (mem_read !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre: rd=%b busy=%b expected 1 1",
               mem_read, busy);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({rd_ack, wr_ack, mem_read, mem_write,
         busy, owner, err} !== 7'b0 ||
        rd_data !== '0 || mem_addr !== '0 ||
        mem_wdata !== '0) begin
      errors++;
      $display("FAIL mid_async: ctrl=%b rdata=%h addr=%h",
               {rd_ack, wr_ack, mem_read, mem_write,
                busy, owner, err},
               rd_data, mem_addr);
    end
    rd_req = 1'b0;
    hang   = 0;
    repeat (2) @(negedge clk);
    rst  = 1'b1;
    ack0 = rd_ack_cnt;
    repeat (4) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || mem_read !== 1'b0) begin
      errors++;
      $display("FAIL mid_idle: busy=%b rd=%b expected 0 0",
               busy, mem_read);
    end
    checks++;
    if (rd_ack_cnt != ack0) begin
      errors++;
      $display("FAIL mid_no_ack: pulses=%0d expected 0",
               rd_ack_cnt - ack0);
    end
  endtask

  initial begin
    rst       = 1'b0;
    rd_req    = 1'b0;
    rd_addr   = '0;
    wr_req    = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    mem_rdata = '0;
    mem_done  = 1'b0;
    test_reset();
    test_single_read();
    test_single_write();
    test_streak();
    test_simultaneous();
    test_done_stuck();
    test_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares the single external SRAM command port (read/write/addr/data/workdone style) between two requesters.
- Requester 0 is the VGA/display read port; requester 1 is the camera frame write port.
- Sits between the pixel datapaths and the SRAM controller, which it sequences with one outstanding command at a time.
- Reads have fixed priority, and a streak counter bounds write starvation.

Parameters:
- ADDR_W, 20, SRAM word address width
- DATA_W, 32, SRAM data width
- MAX_RD_STREAK, 4, maximum consecutive read grants while a write is pending; range 1..15
- TIMEOUT, 255, cycles to wait for mem_done before abort (used only with the optional feature); range 1..255

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low
- rd_req  in  1  read request; held until rd_ack
- rd_addr  in  ADDR_W  read address; stable while rd_req is high
- rd_ack  out  1  one-cycle pulse; rd_data is valid in this cycle
- rd_data  out  DATA_W  read result; held until the next read completes
- wr_req  in  1  write request; held until wr_ack
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- wr_ack  out  1  one-cycle pulse when the write has completed
- mem_read  out  1  read command to the SRAM controller (level)
- mem_write  out  1  write command to the SRAM controller (level)
- mem_addr  out  ADDR_W  command address
- mem_wdata  out  DATA_W  command write data
- mem_rdata  in  DATA_W  read data from the controller; valid while mem_done is high
- mem_done  in  1  controller completion (level)
- busy  out  1  high in any state other than IDLE
- owner  out  1  0 = read owns the port, 1 = write owns the port; valid while busy
- err  out  1  sticky timeout flag (optional feature only; tied 0 otherwise)

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - All outputs are 0, including rd_data, mem_addr and mem_wdata.
  - rd_streak goes to 0.
- States: IDLE, ISSUE, WAIT, ACK.
- IDLE:
  - No grant is made while mem_done=1; the arbiter waits for the previous completion to clear.
  - Otherwise, if any request is pending, arbitrate: write wins when wr_req && (!rd_req || rd_streak==MAX_RD_STREAK); else read wins.
  - The winner's addr (and data for a write) is latched, owner is set, and the state goes to ISSUE.
- ISSUE:
  - mem_read or mem_write is asserted (registered, so visible 1 cycle after the grant), with mem_addr/mem_wdata from the latches.
  - Next state is WAIT.
- WAIT:
  - The command is held until mem_done=1.
  - On that cycle the command is deasserted, mem_rdata is captured into rd_data (reads only), and the state goes to ACK.
- ACK:
  - rd_ack or wr_ack is pulsed for exactly one cycle; the state returns to IDLE.
  - Requests are ignored in ACK, so the requester may drop req on the ack cycle.
- Minimum latency, request to ack: 3 cycles plus controller latency (IDLE grant, ISSUE, WAIT with mem_done, ACK).
- rd_streak update at each grant:
  - Read grant with wr_req=1: increment, saturating at MAX_RD_STREAK.
  - Read grant with wr_req=0: clear to 0.
  - Write grant: clear to 0.
- Simultaneous rd_req and wr_req in IDLE with rd_streak<MAX_RD_STREAK: read is granted.
- A request deasserted before its ack is a protocol violation. The already-latched command still completes and acks.
- Exactly one of mem_read/mem_write may be high at any time; they are never high together.
- Reset mid-command drops mem_read/mem_write immediately. No ack is produced.

Optional Feature:
- SRAM_TIMEOUT_EN defined:
  - An 8-bit counter runs in WAIT.
  - If TIMEOUT cycles elapse without mem_done, the command is deasserted, err is set (sticky until reset), and the ack is pulsed anyway (rd_data is left unchanged) so the requester cannot hang.
- SRAM_TIMEOUT_EN undefined:
  - No counter exists; WAIT waits indefinitely; err is tied 0.

Decomposition:
- Shared package/header holds:
  - state encoding constants (ST_IDLE=0, ST_ISSUE=1, ST_WAIT=2, ST_ACK=3);
  - OWNER_RD=0 and OWNER_WR=1;
  - the SRAM address/data width defaults, shared with the SRAM controller.
- One natural sub-module: sram_arb_prio, the combinational grant decision plus the rd_streak register, kept separate so it can be tested alone.
- The FSM and latches stay in the top module.

Test Plan:
- Single read, rd_addr=0x00123; controller returns 0xDEADBEEF after 2 cycles -> mem_read high cycles 1-3, mem_addr=0x00123, rd_ack pulses at cycle 4 with rd_data=0xDEADBEEF, wr_ack never high.
- Single write, wr_addr=0x0FFFF, wr_data=0x01020304 -> mem_write high with matching addr/data, mem_read stays 0, one wr_ack pulse, rd_data unchanged.
- rd_req held continuously and wr_req raised, MAX_RD_STREAK=4 -> grant order R,R,R,R,W,R,...; the write is granted on the 5th grant.
- Both requests asserted in the same cycle with rd_streak=0 -> read granted first, write granted next; never both mem_read and mem_write high.
- mem_done stuck high after a completion -> no new grant until mem_done falls; then a pending read is issued within 2 cycles.
- rst pulled low in WAIT -> all outputs 0 asynchronously; after release the FSM is in IDLE. With SRAM_TIMEOUT_EN and TIMEOUT=8 and mem_done never asserted, rd_ack pulses 9 cycles after ISSUE and err=1.
